// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch controller.
//   fetch_state_e       - controller state encoding (IDLE, REQ, WAIT, HOLD, DRAIN)
//   INSTR_NOP           - instruction buffer reset value (addi x0, x0, 0)
//   INSTR_BYTES_DEFAULT - default PC increment per accepted instruction
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DRAIN
    } fetch_state_e;

    localparam logic [31:0] INSTR_NOP           = 32'h0000_0013;
    localparam logic [31:0] INSTR_BYTES_DEFAULT = 32'd4;

endpackage

// File: rtl/fetch_controller.sv
// fetch_controller: sequences instruction fetch between the program counter,
// instruction memory and decode. One memory request outstanding at a time;
// the returned word is held in a one-entry buffer behind a valid/ready
// handshake. Branch/jump redirects are absorbed, and a response that was
// already in flight when a redirect arrived is dropped.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   pc                   current PC from the program counter
//   pc_next              next PC to the program counter (combinational)
//   imem_req_valid/addr  fetch request; address is always pc
//   imem_req_ready       memory accepts the request
//   imem_rsp_valid/data  one-cycle response pulse with the instruction word
//   instr_valid/instr/instr_pc  buffered instruction towards decode
//   instr_ready          decode accepts the buffered instruction
//   redirect_valid/pc    taken branch/jump, one-cycle pulse, and its target
//   fetch_misaligned     one-cycle pulse after a misaligned redirect
//                        (only when FETCH_MISALIGN_CHECK_EN is defined)
//
// Build option FETCH_MISALIGN_CHECK_EN: a redirect to a target with
// redirect_pc[1:0] != 0 leaves the PC unchanged, pulses fetch_misaligned and
// parks the controller in IDLE until an aligned redirect or reset. Without it
// the low two target bits are simply forced to zero.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] INSTR_BYTES = INSTR_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    output logic [31:0] pc_next,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        fetch_misaligned
`endif
);

    fetch_state_e state, state_n;
    logic         req_hs;
    logic         accept;
    logic         redir_ok;
    logic         redir_bad;
    logic         parked;
    logic         parked_n;

    assign imem_req_addr = pc;
    assign req_hs        = imem_req_valid && imem_req_ready;
    assign accept        = instr_valid && instr_ready;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign redir_ok  = redirect_valid && !redir_bad;
    // Park state as it will be after this edge; steers the states that
    // would otherwise go to REQ towards IDLE instead.
    assign parked_n  = redir_bad ? 1'b1 : (redir_ok ? 1'b0 : parked);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parked           <= 1'b0;
            fetch_misaligned <= 1'b0;
        end else begin
            parked           <= parked_n;
            fetch_misaligned <= redir_bad;
        end
    end
`else
    assign redir_bad = 1'b0;
    assign redir_ok  = redirect_valid;
    assign parked    = 1'b0;
    assign parked_n  = 1'b0;
`endif

    // A misaligned redirect holds the PC; an accept coinciding with any
    // redirect still completes but the redirect decides the next PC.
    always_comb begin
        if (redir_ok) begin
            pc_next = {redirect_pc[31:2], 2'b00};
        end else if (redirect_valid) begin
            pc_next = pc;
        end else if (accept) begin
            pc_next = pc + INSTR_BYTES;
        end else begin
            pc_next = pc;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  state_n = parked_n ? IDLE : REQ;
            // Redirect without handshake passes through IDLE so valid drops
            // for a cycle and the address never changes under valid.
            REQ: begin
                if (redirect_valid) begin
                    state_n = req_hs ? DRAIN : IDLE;
                end else if (req_hs) begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    if (imem_rsp_valid) begin
                        state_n = parked_n ? IDLE : REQ;
                    end else begin
                        state_n = DRAIN;
                    end
                end else if (imem_rsp_valid) begin
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    state_n = parked_n ? IDLE : REQ;
                end else if (instr_ready) begin
                    state_n = REQ;
                end
            end
            DRAIN: begin
                if (imem_rsp_valid) begin
                    state_n = parked_n ? IDLE : REQ;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they are glitch-free
    // and align exactly with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            imem_req_valid <= 1'b0;
            instr_valid    <= 1'b0;
            instr          <= INSTR_NOP;
            instr_pc       <= '0;
        end else begin
            state          <= state_n;
            imem_req_valid <= (state_n == REQ);
            instr_valid    <= (state_n == HOLD);
            if (state == WAIT && imem_rsp_valid && !redirect_valid) begin
                instr    <= imem_rsp_data;
                instr_pc <= pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: self-checking bench for fetch_controller. Drives a
// program-counter register, a variable-latency instruction memory and a
// decode stage with random back-pressure and redirects, and checks the
// delivered instruction stream and handshake rules against a
// transaction-level model.
module tb_fetch_controller;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fetch_misaligned;
`endif

    fetch_controller #(.INSTR_BYTES(32'd4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc             (pc),
        .pc_next        (pc_next),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .fetch_misaligned (fetch_misaligned)
`endif
    );

    always #5 clk = ~clk;

    // Program counter register fed by pc_next.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= '0;
        else        pc <= pc_next;
    end

    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Memory contents: a fixed scramble of the address; word 0 is 0x00100093.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0010_0093;
    endfunction

    // Stimulus knobs
    int unsigned rdy_pct, acc_pct, redir_pm, spur_pct, lat_min, lat_max;
    logic        force_redir;
    logic [31:0] force_pc;

    // Model state
    logic        mem_busy;
    int unsigned mem_cnt;
    logic [31:0] mem_addr;
    logic [31:0] exp_pc;
    int unsigned n_acc = 0;
    logic        prev_hold, prev_reqwait, prev_bad;
    logic [31:0] prev_instr, prev_ipc, prev_addr;

    task automatic tick();
        logic        was_busy;
        logic        bad_rd;
        logic [31:0] tgt;
        logic [31:0] exp_next;
        @(negedge clk);
        if (prev_hold) begin
            check("hold_valid", instr_valid, 1);
            check("hold_instr", instr, prev_instr);
            check("hold_pc", instr_pc, prev_ipc);
        end
        if (prev_reqwait) begin
            check("req_held", imem_req_valid, 1);
            check("req_addr_held", imem_req_addr, prev_addr);
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        check("misaligned_pulse", fetch_misaligned, prev_bad);
`endif
        was_busy = mem_busy;
        check("one_outstanding", imem_req_valid && (was_busy || instr_valid), 0);
        if (imem_req_valid) check("req_addr_pc", imem_req_addr, pc);

        imem_req_ready = ($urandom_range(99) < rdy_pct);
        instr_ready    = ($urandom_range(99) < acc_pct);
        redirect_valid = 1'b0;
        redirect_pc    = $urandom;
        if (force_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = force_pc;
            force_redir    = 1'b0;
        end else if ($urandom_range(999) < redir_pm) begin
            tgt = {22'h0, 8'($urandom_range(255)), 2'b00};
            if ($urandom_range(7) == 0) tgt = 32'hFFFF_FFF8;
`ifndef FETCH_MISALIGN_CHECK_EN
            tgt[1:0] = 2'($urandom_range(3));
`endif
            redirect_valid = 1'b1;
            redirect_pc    = tgt;
        end

        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (mem_busy) begin
            if (mem_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mem_addr);
                mem_busy       = 1'b0;
            end else begin
                mem_cnt--;
            end
        end else if ($urandom_range(99) < spur_pct) begin
            imem_rsp_valid = 1'b1;
        end
        #1;

        bad_rd = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        bad_rd = redirect_valid && (redirect_pc[1:0] != 2'b00);
`endif
        if (redirect_valid && !bad_rd)     exp_next = {redirect_pc[31:2], 2'b00};
        else if (redirect_valid)           exp_next = pc;
        else if (instr_valid && instr_ready) exp_next = pc + 32'd4;
        else                               exp_next = pc;
        check("pc_next", pc_next, exp_next);

        if (instr_valid && instr_ready) begin
            check("acc_pc", instr_pc, exp_pc);
            check("acc_instr", instr, mem_word(instr_pc));
            exp_pc = exp_pc + 32'd4;
            n_acc++;
        end
        if (redirect_valid && !bad_rd) exp_pc = {redirect_pc[31:2], 2'b00};

        prev_hold    = instr_valid && !instr_ready && !redirect_valid;
        prev_instr   = instr;
        prev_ipc     = instr_pc;
        prev_reqwait = imem_req_valid && !imem_req_ready && !redirect_valid;
        prev_addr    = imem_req_addr;
        prev_bad     = bad_rd;
        if (imem_req_valid && imem_req_ready) begin
            mem_busy = 1'b1;
            mem_addr = imem_req_addr;
            mem_cnt  = $urandom_range(lat_max, lat_min) - 1;
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #1;
        check("rst_instr_valid", instr_valid, 0);
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_instr_pc", instr_pc, 0);
        check("rst_pc_next", pc_next, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("rst_misaligned", fetch_misaligned, 0);
`endif
        mem_busy     = 1'b0;
        mem_cnt      = 0;
        exp_pc       = '0;
        force_redir  = 1'b0;
        prev_hold    = 1'b0;
        prev_reqwait = 1'b0;
        prev_bad     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_req(input string tag, input logic [31:0] addr);
        int unsigned n = 0;
        do begin
            tick();
            n++;
        end while (!imem_req_valid && n < 20);
        check({tag, "_req_valid"}, imem_req_valid, 1);
        check({tag, "_req_addr"}, imem_req_addr, addr);
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] ipc);
        int unsigned n = 0;
        do begin
            tick();
            n++;
        end while (!instr_valid && n < 20);
        check({tag, "_instr_valid"}, instr_valid, 1);
        check({tag, "_instr_pc"}, instr_pc, ipc);
    endtask

    initial begin
        rdy_pct = 100; acc_pct = 0; redir_pm = 0; spur_pct = 0;
        lat_min = 1;   lat_max = 1;
        force_redir = 1'b0; force_pc = '0;
        #2 do_reset();

        // First fetch with a one-cycle memory, then five cycles of back-pressure.
        tick();
        check("t1_req_valid", imem_req_valid, 1);
        check("t1_req_addr", imem_req_addr, 0);
        tick();
        tick();
        check("t1_instr_valid", instr_valid, 1);
        check("t1_instr", instr, 32'h0010_0093);
        check("t1_instr_pc", instr_pc, 0);
        repeat (5) begin
            tick();
            check("t2_no_req", imem_req_valid, 0);
            check("t2_valid", instr_valid, 1);
        end
        acc_pct = 100;
        tick();
        check("t1_pc_next", pc_next, 32'd4);
        acc_pct = 0;
        lat_min = 3; lat_max = 3;
        tick();
        check("t1_req4_valid", imem_req_valid, 1);
        check("t1_req4_addr", imem_req_addr, 32'd4);

        // Redirect while waiting: stale word dropped, refetch at the target.
        force_redir = 1'b1; force_pc = 32'h0000_0100;
        acc_pct = 100; rdy_pct = 0;
        tick();
        wait_req("t3", 32'h0000_0100);

        // Redirect in REQ without handshake: valid drops for one cycle.
        force_redir = 1'b1; force_pc = 32'h0000_0040;
        tick();
        tick();
        check("t4_drop", imem_req_valid, 0);
        tick();
        check("t4_req_valid", imem_req_valid, 1);
        check("t4_req_addr", imem_req_addr, 32'h0000_0040);

        // Wrap of the PC increment at the top of the address space.
        rdy_pct = 100; acc_pct = 0; lat_min = 1; lat_max = 1;
        force_redir = 1'b1; force_pc = 32'hFFFF_FFFC;
        tick();
        wait_valid("t5", 32'hFFFF_FFFC);
        acc_pct = 100;
        tick();
        check("t5_wrap", pc_next, 32'h0);
        acc_pct = 0;

        // Redirect to a misaligned target.
        force_redir = 1'b1; force_pc = 32'h0000_0102;
        tick();
`ifdef FETCH_MISALIGN_CHECK_EN
        tick();
        check("t6_pulse", fetch_misaligned, 1);
        repeat (8) begin
            tick();
            check("t6_parked", imem_req_valid, 0);
        end
        force_redir = 1'b1; force_pc = 32'h0000_0200;
        tick();
        wait_req("t6", 32'h0000_0200);
`else
        wait_req("t6", 32'h0000_0100);
`endif

        // Random traffic with a reset in the middle.
        rdy_pct = 70; acc_pct = 60; redir_pm = 30; spur_pct = 5;
        lat_min = 1;  lat_max = 3;
        repeat (1500) tick();
        #2 do_reset();
        repeat (1500) tick();
        check("progress", n_acc > 200, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequences instruction fetch for the core: drives `pc_next` into the program counter, issues one instruction-memory request at a time at the current `pc`, and buffers the returned word for decode behind a valid/ready handshake. It sits between the program counter, instruction memory and decode. It also absorbs branch/jump redirects, including dropping a stale in-flight response.

## Interface
- `INSTR_BYTES`, 4: PC increment per accepted instruction.
- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pc`  in  32  current PC from the program counter.
- `pc_next`  out  32  next PC to the program counter. Combinational.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_addr`  out  32  fetch address, always equal to `pc`.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_rsp_valid`  in  1  response word valid, one cycle.
- `imem_rsp_data`  in  32  instruction word.
- `instr_valid`  out  1  buffered instruction valid to decode.
- `instr`  out  32  buffered instruction.
- `instr_pc`  out  32  PC of the buffered instruction.
- `instr_ready`  in  1  decode accepts the instruction.
- `redirect_valid`  in  1  branch/jump taken, one cycle.
- `redirect_pc`  in  32  redirect target.
- `fetch_misaligned`  out  1  present only with `FETCH_MISALIGN_CHECK_EN`.

## Operation
- States: IDLE, REQ, WAIT, HOLD, DRAIN. At most one request is outstanding.
- `pc_next` priority:
  - if `redirect_valid`, then `redirect_pc`;
  - else if `instr_valid && instr_ready`, then `pc + INSTR_BYTES`, wrapping modulo 2^32;
  - else `pc`.
- IDLE always goes to REQ.
- REQ drives `imem_req_valid=1`.
  - Handshake with no redirect: go to WAIT.
  - Handshake with redirect: go to DRAIN.
  - Redirect with no handshake: go to IDLE. Valid drops for one cycle, so the address never changes while valid is high.
- WAIT:
  - `imem_rsp_valid` with no redirect: capture `imem_rsp_data` and `pc` into the buffer, go to HOLD.
  - Redirect: go to DRAIN, or to REQ if the response arrives in the same cycle (that response is discarded).
- DRAIN waits for `imem_rsp_valid`, discards the word, then goes to REQ.
- HOLD drives `instr_valid=1`.
  - `instr_ready` or redirect: go to REQ and clear `instr_valid`.
  - Otherwise hold all buffer outputs stable.
- Accept and redirect in the same cycle: decode's handshake completes, and `pc_next` takes `redirect_pc`.
- `imem_rsp_valid` outside WAIT/DRAIN is ignored.
- `instr_valid` is never high outside HOLD.

## Timing
- Reset values: state IDLE, `instr_valid=0`, `instr=32'h0000_0013` (NOP), `instr_pc=0`, `imem_req_valid=0`, `fetch_misaligned=0`.
- Cycle 1 after `rst_n` rises: IDLE. Cycle 2: REQ.
- With `imem_req_ready=1` and a one-cycle memory: REQ at c, response at c+1, `instr_valid` at c+2, next REQ at c+3.
- Best-case throughput is 1 instruction per 3 cycles.
- Redirect latency: the program counter loads `redirect_pc` on the next edge. The first request to the target is issued:
  - at most 2 cycles later when not draining;
  - otherwise after the stale response arrives.
- `rst_n` asserted mid-transaction: immediate return to reset values. Any later memory response is ignored (arrives in IDLE/REQ).

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[1:0]!=0` does not update the PC; `pc_next=pc`.
  - `fetch_misaligned` pulses for one cycle on the next edge.
  - State goes to DRAIN if a request is outstanding, otherwise IDLE, and then parks in IDLE with no requests.
  - The only exits are an aligned redirect (to REQ) or reset.
- Not defined: the port is absent and `pc_next` uses `{redirect_pc[31:2],2'b00}`.

## Structure
- Package `fetch_pkg`: `fetch_state_e` enum (IDLE, REQ, WAIT, HOLD, DRAIN), `INSTR_NOP=32'h0000_0013`.
- `INSTR_BYTES` default comes from the package.
- Single module, no sub-module. The buffer is three registers inside the controller.

## Test plan
- Reset release, `imem_req_ready=1`, one-cycle memory returning `32'h0010_0093` at addr 0: expect `instr_valid` with `instr_pc=0`; accept, then `pc_next=4` and a request at addr 4.
- `instr_ready=0` for 5 cycles in HOLD: `instr`/`instr_pc` stable, no new request, `pc_next=pc`.
- Redirect to `32'h0000_0100` while in WAIT: the stale response is discarded, `instr_valid` never shows it, and the next request address is `0x100`.
- Redirect in REQ with `imem_req_ready=0`: `imem_req_valid` drops for one cycle, then re-asserts with addr = target.
- `pc=32'hFFFF_FFFC` accepted: `pc_next=0`.
- With macro, redirect to `0x102`:
  - `fetch_misaligned` pulses once and no requests follow;
  - a redirect to `0x200` resumes fetching there.
- Without macro, redirect to `0x102`: request at `0x100`.
